// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the boot path.
// Holds the boot sequencer state encoding and its default bus widths.
// No logic; types and constants only.
package cpu_pkg;

  localparam int BOOT_ADDR_W = 4;
  localparam int BOOT_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_ADDR,
    S_DATA,
    S_DONE
  } boot_state_t;

endpackage

// File: rtl/boot_sequencer_if.sv
// Program-byte stream from the boot source (UART rx / ROM reader).
// Plain valid/ready: a byte moves on a clock edge where both are high.
// The source must hold byte_data stable while byte_valid is high and byte_ready low.
interface boot_sequencer_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] byte_data;
  logic              byte_valid;
  logic              byte_ready;

  modport master (output byte_data, output byte_valid, input byte_ready);
  modport slave  (input byte_data, input byte_valid, output byte_ready);

endinterface

// File: rtl/boot_sequencer.sv
// Boot loader sequencer: writes LOAD_LEN streamed bytes to RAM 0.. via MAR/RAM phases.
// Latency: 3 cycles per byte minimum (wait, address, data) plus one done cycle.
// Backpressure: byte_ready only in S_WAIT_BYTE; the source holds its byte otherwise.
module boot_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W        = BOOT_ADDR_W,
  parameter int DATA_W        = BOOT_DATA_W,
  parameter int LOAD_LEN      = 16,
  parameter bit BOOT_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  boot_sequencer_if.slave    byte_if,
  output logic               bootload_address,
  output logic               bootload_ram,
  output logic [DATA_W-1:0]  boot_bus_data,
  output logic               cpu_hold,
  output logic               cpu_restart,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  load_addr
);

  localparam boot_state_t       RESET_STATE = BOOT_ON_RESET ? S_WAIT_BYTE : S_IDLE;
  // Terminal compare is against the last address, so the counter never wraps.
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(LOAD_LEN - 1);

  boot_state_t       state;
  logic [DATA_W-1:0] byte_q;

  // Sequencer state, address counter and captured byte; abort beats every transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RESET_STATE;
      load_addr <= '0;
      byte_q    <= '0;
    end else if (abort) begin
      state     <= S_IDLE;
      load_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_WAIT_BYTE;
            load_addr <= '0;
          end
        end
        S_WAIT_BYTE: begin
          if (byte_if.byte_valid) begin
            byte_q <= byte_if.byte_data;
            state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          state <= S_DATA;
        end
        S_DATA: begin
          if (load_addr == LAST_ADDR) begin
            state <= S_DONE;
          end else begin
            load_addr <= load_addr + 1'b1;
            state     <= S_WAIT_BYTE;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          load_addr <= '0;
        end
        default: begin
          state     <= S_IDLE;
          load_addr <= '0;
        end
      endcase
    end
  end

  // Outputs decode from registered state only, so byte_valid never reaches the control unit combinationally.
  always_comb begin
    byte_if.byte_ready = 1'b0;
    bootload_address   = 1'b0;
    bootload_ram       = 1'b0;
    boot_bus_data      = '0;
    cpu_hold           = 1'b0;
    cpu_restart        = 1'b0;
    busy               = 1'b0;
    done               = 1'b0;
    case (state)
      S_WAIT_BYTE: begin
        byte_if.byte_ready = 1'b1;
        busy               = 1'b1;
        cpu_hold           = 1'b1;
      end
      S_ADDR: begin
        bootload_address = 1'b1;
        boot_bus_data    = DATA_W'(load_addr);
        busy             = 1'b1;
        cpu_hold         = 1'b1;
      end
      S_DATA: begin
        bootload_ram  = 1'b1;
        boot_bus_data = byte_q;
        busy          = 1'b1;
        cpu_hold      = 1'b1;
      end
      S_DONE: begin
        done        = 1'b1;
        cpu_restart = 1'b1;
        cpu_hold    = 1'b1;
        busy        = 1'b1;
      end
      default: begin
        cpu_hold = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
- Sequences the CPU's bootload path.
- Accepts a stream of program bytes over a valid/ready handshake and writes them into RAM addresses 0..LOAD_LEN-1.
- For each byte, drives the control unit's bootload_address phase (address to MAR), then its bootload_ram phase (data to RAM), presenting the value to the bus driver each time.
- Holds the CPU for the whole load, then issues a one-cycle CPU restart request.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, bus/byte width.
- LOAD_LEN, 16, bytes per load (1..2**ADDR_W).
- BOOT_ON_RESET, 1, if 1, leaves reset directly into S_WAIT_BYTE as if start were seen.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  begin a load; sampled only in S_IDLE.
- abort  in  1  cancel a load; return to S_IDLE next edge.
- byte_data  in  DATA_W  program byte from source (UART rx / ROM reader).
- byte_valid  in  1  byte_data valid.
- byte_ready  out  1  sequencer can accept a byte.
- bootload_address  out  1  to control unit: boot value -> MAR.
- bootload_ram  out  1  to control unit: boot value -> RAM.
- boot_bus_data  out  DATA_W  value the bus driver places on the bus when boot_write_to_bus is active.
- cpu_hold  out  1  CPU frozen (clock gate / reset hold).
- cpu_restart  out  1  one-cycle pulse: reset PC and step counter.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse: load completed.
- load_addr  out  ADDR_W  address currently being loaded.

Behaviour:
- All outputs are registered or decoded from state only; no comb path from byte_valid to bootload_* outputs.
- Reset: state = S_WAIT_BYTE if BOOT_ON_RESET else S_IDLE; load_addr=0; data register=0; all outputs 0 except:
  - byte_ready and busy follow state.
  - cpu_hold is 1 when BOOT_ON_RESET=1.
- States:
  - S_IDLE: outputs 0. start=1 -> S_WAIT_BYTE, load_addr=0.
  - S_WAIT_BYTE: byte_ready=1, busy=1, cpu_hold=1. On valid&ready, capture byte_data -> S_ADDR. Waits indefinitely.
  - S_ADDR (1 cycle): bootload_address=1; boot_bus_data={zeros, load_addr}. Next state S_DATA.
  - S_DATA (1 cycle): bootload_ram=1; boot_bus_data=captured byte.
    - load_addr==LOAD_LEN-1 -> S_DONE.
    - otherwise load_addr+1 -> S_WAIT_BYTE.
  - S_DONE (1 cycle): done=1, cpu_restart=1, cpu_hold=1, busy=1. Next state S_IDLE.
- cpu_hold=1 in every state except S_IDLE. It drops the cycle after the cpu_restart pulse, so the CPU restarts at PC=0 on a clean step counter.
- bootload_address and bootload_ram are never both 1; the control unit treats both high as a no-op.
- boot_bus_data=0 outside S_ADDR/S_DATA.
- Timing:
  - Per byte: minimum 3 cycles (WAIT, ADDR, DATA).
  - Full load with byte_valid held high: 3*LOAD_LEN cycles, plus 1 DONE cycle.
- Boundaries:
  - load_addr never wraps; the terminal compare is against LOAD_LEN-1.
  - start while busy: ignored.
  - start and abort together in S_IDLE: abort wins, stay in S_IDLE.
  - abort in any busy state -> S_IDLE next edge. No done or cpu_restart pulse; cpu_hold drops; load_addr reset to 0.
  - abort during S_DATA: that cycle's RAM write still completes, since outputs are already asserted. RAM contents after abort are undefined.
  - byte_valid in a state other than S_WAIT_BYTE: not accepted (byte_ready=0); the source must hold the byte.
  - Async rst mid-load: immediate return to the reset state; outputs deassert asynchronously.

Decomposition:
- Shared package cpu_pkg gets:
  - boot_state_t enum {S_IDLE, S_WAIT_BYTE, S_ADDR, S_DATA, S_DONE};
  - constants BOOT_ADDR_W=4, BOOT_DATA_W=8.
- Single module, no sub-module. The address counter and byte register are inline; total size is about 150-200 lines.

Test Plan:
- BOOT_ON_RESET=1, release rst, stream bytes 0x10..0x1F with byte_valid always 1:
  - bootload_address at cycles 1,4,7,... with boot_bus_data=0x00..0x0F;
  - bootload_ram on the following cycles with 0x10..0x1F;
  - done and cpu_restart at cycle 48; cpu_hold=0 at cycle 49.
- Source stalls: byte_valid low for 5 cycles before byte 3 -> sequencer holds S_WAIT_BYTE, byte_ready=1 throughout, no bootload_* pulses; the load resumes correctly and memory equals the stream.
- BOOT_ON_RESET=0: start pulse in S_IDLE -> byte_ready next cycle. A second start mid-load -> no effect; load_addr unchanged.
- abort asserted during the S_DATA cycle of address 5 -> that write is observed, next cycle S_IDLE, busy=0, cpu_hold=0, no done pulse. A restart reloads from address 0.
- Async rst asserted between clock edges during S_ADDR -> bootload_address, boot_bus_data and busy drop immediately, and load_addr=0.
- Every cycle of every test: assertion !(bootload_address && bootload_ram), and boot_bus_data==0 outside S_ADDR/S_DATA.
